// File: rtl/axis_text_frame_packer.sv
// rtl/axis_text_frame_packer.sv - ASCII AXI-Stream to 4x16 text frame packer
//
// Purpose: accepts a stream of 8-bit ASCII characters, places them into a
// 4-line x 16-column text frame (with LF/CR cursor control and substitution
// of unsupported codes), then presents the frame as four 128-bit line
// strings behind a valid/ready handshake.
//
// Optional feature macro: AXIS_TEXT_SCROLL_EN
//   defined   - writes/LF past the last line scroll the frame up one line
//   undefined - writes past the last line are dropped and overflow is flagged
//
// Ports:
//   clk                in   system clock
//   reset              in   asynchronous, active-high reset
//   s_axis_tdata[7:0]  in   ASCII character
//   s_axis_tvalid      in   input beat valid
//   s_axis_tready      out  input ready (FILL state only)
//   s_axis_tlast       in   last character of frame
//   m_axis_tdata_str1  out  line 0, bits [127:120] = column 0
//   m_axis_tdata_str2  out  line 1
//   m_axis_tdata_str3  out  line 2
//   m_axis_tdata_str4  out  line 3
//   m_axis_tvalid      out  frame valid
//   m_axis_tready      in   frame accepted
//   overflow           out  frame dropped characters (valid with m_axis_tvalid)

module axis_text_frame_packer #(
  parameter logic [7:0]  PAD_CHAR       = 8'h20,
  parameter logic [7:0]  SUB_CHAR       = 8'h3F,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic         s_axis_tlast,
  output logic [127:0] m_axis_tdata_str1,
  output logic [127:0] m_axis_tdata_str2,
  output logic [127:0] m_axis_tdata_str3,
  output logic [127:0] m_axis_tdata_str4,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic         overflow
);

  typedef enum logic {ST_FILL, ST_PRESENT} state_t;

  localparam logic [127:0] PAD_LINE = {16{PAD_CHAR}};

  state_t       r_state;
  logic [127:0] r_line [4];
  logic [2:0]   r_row;        // value 4 means "past the last line"
  logic [3:0]   r_col;
  logic         r_s_tready;
  logic         r_m_tvalid;
  logic         r_overflow;
  logic         r_started;    // at least one beat accepted in this frame
  logic [31:0]  r_to_cnt;

  logic         w_accept;
  logic         w_is_lf;
  logic         w_is_cr;
  logic         w_is_print;
  logic [7:0]   w_char;
  logic         w_past;
  logic [6:0]   w_bitpos;
  logic [3:0]   w_adv_col;
  logic [2:0]   w_adv_row;
  logic         w_timeout;

  assign w_accept   = s_axis_tvalid && r_s_tready;
  assign w_is_lf    = (s_axis_tdata == 8'h0A);
  assign w_is_cr    = (s_axis_tdata == 8'h0D);
  assign w_is_print = (s_axis_tdata >= 8'h20) && (s_axis_tdata <= 8'h7E);
  assign w_char     = w_is_print ? s_axis_tdata : SUB_CHAR;
  assign w_past     = r_row[2];
  // Column 0 occupies the top byte, so the byte offset is (15 - col) * 8.
  assign w_bitpos   = {~r_col, 3'b000};
  // Column wraps naturally in 4 bits; row advances only when col was 15.
  assign w_adv_col  = r_col + 4'd1;
  assign w_adv_row  = (r_col == 4'd15) ? r_row + 3'd1 : r_row;
  // A beat accepted in the same cycle always takes precedence over the timeout.
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_state == ST_FILL) && r_started &&
                      !w_accept && ((r_to_cnt + 32'd1) == TIMEOUT_CYCLES);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_FILL;
      for (int i = 0; i < 4; i++) r_line[i] <= PAD_LINE;
      r_row      <= 3'd0;
      r_col      <= 4'd0;
      r_s_tready <= 1'b0;
      r_m_tvalid <= 1'b0;
      r_overflow <= 1'b0;
      r_started  <= 1'b0;
      r_to_cnt   <= 32'd0;
    end else begin
      case (r_state)
        ST_FILL: begin
          r_s_tready <= 1'b1;
          if (w_accept) begin
            r_started <= 1'b1;
            r_to_cnt  <= 32'd0;
`ifdef AXIS_TEXT_SCROLL_EN
            if (w_is_lf) begin
              r_col <= 4'd0;
              if (r_row >= 3'd3) begin
                r_line[0] <= r_line[1];
                r_line[1] <= r_line[2];
                r_line[2] <= r_line[3];
                r_line[3] <= PAD_LINE;
                r_row     <= 3'd3;
              end else begin
                r_row <= r_row + 3'd1;
              end
            end else if (w_is_cr) begin
              r_col <= 4'd0;
            end else if (w_past) begin
              // Scroll and place the pending character at (3,0) in one step.
              r_line[0] <= r_line[1];
              r_line[1] <= r_line[2];
              r_line[2] <= r_line[3];
              r_line[3] <= {w_char, {15{PAD_CHAR}}};
              r_row     <= 3'd3;
              r_col     <= 4'd1;
            end else begin
              r_line[r_row[1:0]][w_bitpos +: 8] <= w_char;
              r_col <= w_adv_col;
              r_row <= w_adv_row;
            end
`else
            if (w_past) begin
              // Frame is full: drop writes, ignore LF/CR.
              if (!w_is_lf && !w_is_cr) r_overflow <= 1'b1;
            end else if (w_is_lf) begin
              r_col <= 4'd0;
              r_row <= r_row + 3'd1;
            end else if (w_is_cr) begin
              r_col <= 4'd0;
            end else begin
              r_line[r_row[1:0]][w_bitpos +: 8] <= w_char;
              r_col <= w_adv_col;
              r_row <= w_adv_row;
            end
`endif
            if (s_axis_tlast) begin
              r_state    <= ST_PRESENT;
              r_m_tvalid <= 1'b1;
              r_s_tready <= 1'b0;
            end
          end else if (w_timeout) begin
            r_state    <= ST_PRESENT;
            r_m_tvalid <= 1'b1;
            r_s_tready <= 1'b0;
          end else if (r_started && (TIMEOUT_CYCLES != 0)) begin
            r_to_cnt <= r_to_cnt + 32'd1;
          end
        end

        ST_PRESENT: begin
          if (m_axis_tready) begin
            for (int i = 0; i < 4; i++) r_line[i] <= PAD_LINE;
            r_row      <= 3'd0;
            r_col      <= 4'd0;
            r_overflow <= 1'b0;
            r_started  <= 1'b0;
            r_to_cnt   <= 32'd0;
            r_state    <= ST_FILL;
            r_m_tvalid <= 1'b0;
            r_s_tready <= 1'b1;
          end
        end

        default: r_state <= ST_FILL;
      endcase
    end
  end

  assign s_axis_tready     = r_s_tready;
  assign m_axis_tvalid     = r_m_tvalid;
  assign overflow          = r_overflow;
  assign m_axis_tdata_str1 = r_line[0];
  assign m_axis_tdata_str2 = r_line[1];
  assign m_axis_tdata_str3 = r_line[2];
  assign m_axis_tdata_str4 = r_line[3];

endmodule

// File: tb/tb_axis_text_frame_packer.sv
// tb/tb_axis_text_frame_packer.sv - self-checking bench for axis_text_frame_packer

module tb_axis_text_frame_packer;

  localparam logic [127:0] PAD_LINE = {16{8'h20}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [7:0]   s_tdata;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;
  logic [127:0] str1, str2, str3, str4;
  logic         m_tvalid;
  logic         m_tready;
  logic         ovf;

  logic [7:0]   t_tdata;
  logic         t_tvalid;
  logic         t_tlast;
  logic         t_tready;
  logic [127:0] t_str1, t_str2, t_str3, t_str4;
  logic         t_mvalid;
  logic         t_mready;
  logic         t_ovf;

  axis_text_frame_packer dut (
    .clk               (clk),
    .reset             (reset),
    .s_axis_tdata      (s_tdata),
    .s_axis_tvalid     (s_tvalid),
    .s_axis_tready     (s_tready),
    .s_axis_tlast      (s_tlast),
    .m_axis_tdata_str1 (str1),
    .m_axis_tdata_str2 (str2),
    .m_axis_tdata_str3 (str3),
    .m_axis_tdata_str4 (str4),
    .m_axis_tvalid     (m_tvalid),
    .m_axis_tready     (m_tready),
    .overflow          (ovf)
  );

  axis_text_frame_packer #(.TIMEOUT_CYCLES(8)) dut_to (
    .clk               (clk),
    .reset             (reset),
    .s_axis_tdata      (t_tdata),
    .s_axis_tvalid     (t_tvalid),
    .s_axis_tready     (t_tready),
    .s_axis_tlast      (t_tlast),
    .m_axis_tdata_str1 (t_str1),
    .m_axis_tdata_str2 (t_str2),
    .m_axis_tdata_str3 (t_str3),
    .m_axis_tdata_str4 (t_str4),
    .m_axis_tvalid     (t_mvalid),
    .m_axis_tready     (t_mready),
    .overflow          (t_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: a 4x16 character grid filled by the textual rules.
  byte unsigned txq[$];
  logic [127:0] exp_line [4];
  logic         exp_ovf;

  task automatic model_frame();
    byte unsigned cells [4][16];
    int row, col;
    byte unsigned ch;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 16; j++) cells[i][j] = 8'h20;
    row = 0; col = 0; exp_ovf = 1'b0;
    for (int k = 0; k < txq.size(); k++) begin
      ch = txq[k];
      if (row > 3) begin
        if (ch != 8'h0A && ch != 8'h0D) exp_ovf = 1'b1;
      end else if (ch == 8'h0A) begin
        row = row + 1; col = 0;
      end else if (ch == 8'h0D) begin
        col = 0;
      end else begin
        cells[row][col] = (ch >= 8'h20 && ch <= 8'h7E) ? ch : 8'h3F;
        col = col + 1;
        if (col == 16) begin col = 0; row = row + 1; end
      end
    end
    for (int i = 0; i < 4; i++) begin
      exp_line[i] = '0;
      for (int j = 0; j < 16; j++) exp_line[i] = {exp_line[i][119:0], cells[i][j]};
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int guard;
    guard = 0;
    s_tdata = d; s_tvalid = 1'b1; s_tlast = last;
    while (s_tready !== 1'b1 && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 200) check("beat_accept_bound", 1'b0, 1'b1);
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_only(input bit gaps);
    int n;
    n = txq.size();
    for (int i = 0; i < n; i++) begin
      send_beat(txq[i], i == n - 1);
      if (gaps && i != n - 1) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic run_frame(input string tag, input int hold, input bit gaps, input bit drive_valid);
    model_frame();
    send_only(gaps);
    check({tag, "_tvalid"}, m_tvalid, 1'b1);
    check({tag, "_str1"}, str1, exp_line[0]);
    check({tag, "_str2"}, str2, exp_line[1]);
    check({tag, "_str3"}, str3, exp_line[2]);
    check({tag, "_str4"}, str4, exp_line[3]);
    check({tag, "_ovf"}, ovf, exp_ovf);
    if (drive_valid) begin s_tdata = 8'h51; s_tvalid = 1'b1; end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, "_hold_tvalid"}, m_tvalid, 1'b1);
      check({tag, "_hold_tready"}, s_tready, 1'b0);
      check({tag, "_hold_str1"}, str1, exp_line[0]);
      check({tag, "_hold_str4"}, str4, exp_line[3]);
    end
    m_tready = 1'b1;
    @(posedge clk); #1;
    m_tready = 1'b0; s_tvalid = 1'b0;
    check({tag, "_hs_tvalid"}, m_tvalid, 1'b0);
    check({tag, "_hs_str1"}, str1, PAD_LINE);
    check({tag, "_hs_str4"}, str4, PAD_LINE);
    check({tag, "_hs_ovf"}, ovf, 1'b0);
    check({tag, "_hs_tready"}, s_tready, 1'b1);
    txq.delete();
  endtask

  task automatic push_string(input string s);
    for (int i = 0; i < s.len(); i++) txq.push_back(s[i]);
  endtask

  function automatic byte unsigned rand_char();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 8'h0A;
    if (r == 1) return 8'h0D;
    if (r == 2) return byte'($urandom_range(0, 31));
    if (r == 3) return byte'($urandom_range(127, 255));
    return byte'($urandom_range(32, 126));
  endfunction

  task automatic to_beat(input logic [7:0] d);
    int guard;
    guard = 0;
    t_tdata = d; t_tvalid = 1'b1; t_tlast = 1'b0;
    while (t_tready !== 1'b1 && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 200) check("to_accept_bound", 1'b0, 1'b1);
    @(posedge clk); #1;
    t_tvalid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    t_tdata = 8'h00; t_tvalid = 1'b0; t_tlast = 1'b0; t_mready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_tvalid, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_tready", s_tready, 1'b0);
    check("rst_str1", str1, PAD_LINE);
    check("rst_str4", str4, PAD_LINE);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_tready_low", s_tready, 1'b0);
    @(posedge clk); #1;
    check("rel_tready_high", s_tready, 1'b1);

    // HELLO
    push_string("HELLO");
    check("t1_const_model", exp_line[0], exp_line[0] ^ '0);
    model_frame();
    check("t1_model_str1", exp_line[0], {"HELLO", {11{8'h20}}});
    run_frame("t1", 0, 1'b0, 1'b0);

    // LF / CR handling
    push_string("AB\nCD\rE");
    model_frame();
    check("t2_model_str2", exp_line[1], {"ED", {14{8'h20}}});
    run_frame("t2", 1, 1'b0, 1'b0);

    // 70 characters: overflow on the tail, tlast beat itself dropped
    for (int i = 0; i < 70; i++) txq.push_back(byte'(8'h61 + i));
    model_frame();
    check("t3_model_ovf", exp_ovf, 1'b1);
    run_frame("t3", 2, 1'b0, 1'b0);

    // Backpressure on the frame output with input valid held high
    push_string("BP test");
    run_frame("t4", 10, 1'b0, 1'b1);

    // Empty frame: a lone CR with tlast
    txq.push_back(8'h0D);
    run_frame("empty", 0, 1'b0, 1'b0);

    // Exactly 64 printable characters then tlast on a LF: full, no overflow
    for (int i = 0; i < 64; i++) txq.push_back(byte'(8'h30 + (i % 40)));
    txq.push_back(8'h0A);
    run_frame("full64", 1, 1'b0, 1'b0);

    // Randomised frames with input gaps
    for (int f = 0; f < 25; f++) begin
      int len;
      len = $urandom_range(1, 80);
      for (int i = 0; i < len; i++) txq.push_back(rand_char());
      run_frame($sformatf("rnd%0d", f), $urandom_range(0, 3), 1'b1, 1'b0);
    end

    // Timeout: tvalid exactly 8 edges after the accepting edge
    to_beat(8'h5A);
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("to_early%0d", k), t_mvalid, 1'b0);
    end
    @(posedge clk); #1;
    check("to_fire", t_mvalid, 1'b1);
    check("to_char", t_str1[127:120], 8'h5A);
    check("to_tready", t_tready, 1'b0);
    t_mready = 1'b1; @(posedge clk); #1; t_mready = 1'b0;
    check("to_hs", t_mvalid, 1'b0);

    // Timeout counter restarts on each accepted beat
    to_beat(8'h5A);
    repeat (5) begin @(posedge clk); #1; end
    check("to2_none", t_mvalid, 1'b0);
    to_beat(8'h59);
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("to2_early%0d", k), t_mvalid, 1'b0);
    end
    @(posedge clk); #1;
    check("to2_fire", t_mvalid, 1'b1);
    check("to2_str1", t_str1, {"ZY", {14{8'h20}}});
    t_mready = 1'b1; @(posedge clk); #1; t_mready = 1'b0;

    // Reset while a frame is being presented
    push_string("RST");
    send_only(1'b0);
    check("r6_pre_tvalid", m_tvalid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("r6_tvalid", m_tvalid, 1'b0);
    check("r6_str1", str1, PAD_LINE);
    check("r6_tready", s_tready, 1'b0);
    txq.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("r6_rel_low", s_tready, 1'b0);
    @(posedge clk); #1;
    check("r6_rel_high", s_tready, 1'b1);

    // Frame after mid-operation reset starts from a clean grid
    push_string("OK");
    run_frame("post_rst", 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
